// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control token constants, symbol width and receiver state type
package tmds_pkg;

    localparam int TMDS_SYM_W = 10;

    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational 10b->8b TMDS decode with control token match
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [TMDS_SYM_W-1:0] q,
    output logic [7:0]            data,
    output logic                  is_ctrl,
    output logic [1:0]            ctrl
);

    logic [7:0] d;

    always_comb begin
        d       = q[9] ? ~q[7:0] : q[7:0];
        data    = 8'h00;
        data[0] = d[0];
        // q[8] selects XOR vs XNOR chaining used by the encoder
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (q)
            TMDS_CTRL_00: ctrl = 2'b00;
            TMDS_CTRL_01: ctrl = 2'b01;
            TMDS_CTRL_10: ctrl = 2'b10;
            TMDS_CTRL_11: ctrl = 2'b11;
            default:      is_ctrl = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_channel_rx.sv
// rtl/tmds_channel_rx.sv - TMDS channel receiver: deserialize, align on control tokens, decode
// Optional statistics counters enabled by TMDS_RX_STATS_EN.
module tmds_channel_rx
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int SLIP_LIMIT = 4
) (
    input  logic                  clk_tmds,
    input  logic                  rst_n,
    input  logic                  serial_in,
    output logic                  symbol_valid,
    output logic [TMDS_SYM_W-1:0] symbol,
    output logic [7:0]            data_out,
    output logic                  data_enable,
    output logic [1:0]            control_out,
    output logic                  locked,
    output logic                  slip_event,
    output logic [15:0]           vsync_count,
    output logic [7:0]            unlock_count
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] SLIP_LIM = 4'(SLIP_LIMIT);

    rx_state_t             state, state_next;
    logic [TMDS_SYM_W-1:0] window;
    logic [3:0]            phase, phase_next;
    logic [3:0]            match_cnt, match_next;
    logic [3:0]            slip_cnt, slip_next, slip_inc;
    logic                  boundary, emit, lose;
    logic                  tok_match;
    logic [1:0]            tok_ctrl;
    logic [7:0]            dec_data;

    tmds_symbol_decode u_decode (
        .q       (window),
        .data    (dec_data),
        .is_ctrl (tok_match),
        .ctrl    (tok_ctrl)
    );

    assign boundary = (phase == 4'd9);

    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            phase     <= 4'd0;
            match_cnt <= 4'd0;
            slip_cnt  <= 4'd0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            match_cnt <= match_next;
            slip_cnt  <= slip_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = boundary ? 4'd0 : phase + 4'd1;
        match_next = match_cnt;
        slip_next  = slip_cnt;
        emit       = 1'b0;
        lose       = 1'b0;
        slip_inc   = (slip_cnt == 4'hF) ? slip_cnt : slip_cnt + 4'd1;
        case (state)
            SEARCH: begin
                if (tok_match) begin
                    phase_next = 4'd0;
                    match_next = 4'd1;
                    state_next = VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (!tok_match) begin
                        match_next = 4'd0;
                        state_next = SEARCH;
                    end else if (match_cnt + 4'd1 == LOCK_CNT) begin
                        match_next = 4'd0;
                        slip_next  = 4'd0;
                        state_next = LOCKED;
                    end else begin
                        match_next = match_cnt + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (tok_match) slip_next = 4'd0;
                end else if (tok_match) begin
                    // a token seen off-phase means the bit stream has slipped
                    if (slip_inc >= SLIP_LIM) begin
                        slip_next  = 4'd0;
                        lose       = 1'b1;
                        state_next = SEARCH;
                    end else begin
                        slip_next = slip_inc;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            window       <= '0;
            symbol_valid <= 1'b0;
            symbol       <= '0;
            data_out     <= 8'h00;
            data_enable  <= 1'b0;
            control_out  <= 2'b00;
            locked       <= 1'b0;
            slip_event   <= 1'b0;
        end else begin
            window       <= {window[TMDS_SYM_W-2:0], serial_in};
            symbol_valid <= emit;
            slip_event   <= lose;
            locked       <= (state_next == LOCKED);
            if (emit) begin
                symbol <= window;
                if (tok_match) begin
                    data_enable <= 1'b0;
                    control_out <= tok_ctrl;
                end else begin
                    data_enable <= 1'b1;
                    data_out    <= dec_data;
                end
            end
        end
    end

`ifdef TMDS_RX_STATS_EN
    logic [15:0] vsync_q;
    logic [7:0]  unlock_q;

    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 16'h0000;
            unlock_q <= 8'h00;
        end else begin
            // control_out still holds the previous token's c1 here
            if (emit && tok_match && tok_ctrl[1] && !control_out[1])
                vsync_q <= vsync_q + 16'd1;
            if (lose && unlock_q != 8'hFF)
                unlock_q <= unlock_q + 8'd1;
        end
    end

    assign vsync_count  = vsync_q;
    assign unlock_count = unlock_q;
`else
    assign vsync_count  = 16'h0000;
    assign unlock_count = 8'h00;
`endif

endmodule
